// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Steps an 8-LED bank through one of four display patterns at a
//   programmable rate. A prescaler produces the step tick. A mode register
//   acts as the FSM state and selects which pattern advances on each tick.
//   A req/ack handshake changes the mode only on a tick boundary, or on the
//   next edge while paused, so the LEDs never show a partial pattern.
//
// Ports
//   clk        in   1  system clock, posedge
//   rst_n      in   1  asynchronous active-low reset
//   mode_req   in   1  mode-change request, held until mode_ack
//   mode_sel   in   2  requested mode (0 OFF, 1 BINARY, 2 CHASE, 3 BOUNCE)
//   mode_ack   out  1  one-cycle pulse: requested mode applied this cycle
//   speed      in   2  rate select, step period = TICK_DIV >> speed cycles
//   pause      in   1  freezes prescaler and pattern
//   mode       out  2  currently active mode
//   step_tick  out  1  one-cycle pulse on every pattern step
//   led        out  8  LED drive, active high
module led_pattern_sequencer #(
    parameter int TICK_DIV = 1_500_000,
    parameter int CNT_W    = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_req,
    input  logic [1:0] mode_sel,
    output logic       mode_ack,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic [1:0] mode,
    output logic       step_tick,
    output logic [7:0] led
);

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_BINARY = 2'd1,
        M_CHASE  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

    mode_t            state, state_nxt;
    dir_t             dir, dir_nxt;
    logic [7:0]       led_nxt;
    logic             ack_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] lim_m1;
    logic             tick_nxt;
    logic             apply;

    assign limit  = DIV >> speed;
    assign lim_m1 = limit - CNT_W'(1);

    // ">=" rather than "==": if speed rises mid-count the counter may already
    // be past the new limit, so it ticks at once instead of wrapping round.
    assign tick_nxt = !pause && (cnt >= lim_m1);

    // A request is applied on a tick edge, or on the next edge when paused.
    // It is ignored while the previous ack is still high, so a request that
    // is held one cycle too long cannot be applied twice.
    assign apply = mode_req && !mode_ack && (pause || tick_nxt);

    assign mode = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            step_tick <= 1'b0;
        end else if (pause) begin
            step_tick <= 1'b0;
        end else if (tick_nxt) begin
            cnt       <= '0;
            step_tick <= 1'b1;
        end else begin
            cnt       <= cnt + CNT_W'(1);
            step_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= M_OFF;
            dir      <= DIR_LEFT;
            led      <= 8'h00;
            mode_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            led      <= led_nxt;
            mode_ack <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        led_nxt   = led;
        ack_nxt   = 1'b0;

        if (apply) begin
            // A newly applied mode starts from its first frame; the tick
            // that carries the change does not also advance the pattern.
            state_nxt = mode_t'(mode_sel);
            ack_nxt   = 1'b1;
            dir_nxt   = DIR_LEFT;
            case (mode_t'(mode_sel))
                M_CHASE, M_BOUNCE: led_nxt = 8'h01;
                default:           led_nxt = 8'h00;
            endcase
        end else if (tick_nxt) begin
            case (state)
                M_OFF:    led_nxt = 8'h00;
                M_BINARY: led_nxt = led + 8'h01;
                M_CHASE:  led_nxt = {led[6:0], led[7]};
                M_BOUNCE: begin
                    // Each end is shown once, then the direction flips and
                    // the next frame is already one step back inside.
                    if (dir == DIR_LEFT) begin
                        if (led == 8'h80) begin
                            dir_nxt = DIR_RIGHT;
                            led_nxt = 8'h40;
                        end else begin
                            led_nxt = led << 1;
                        end
                    end else begin
                        if (led == 8'h01) begin
                            dir_nxt = DIR_LEFT;
                            led_nxt = 8'h02;
                        end else begin
                            led_nxt = led >> 1;
                        end
                    end
                end
                default:  led_nxt = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with TICK_DIV=16. Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic [1:0] speed;
    logic       pause;
    logic [1:0] mode;
    logic       step_tick;
    logic [7:0] led;

    int checks   = 0;
    int failures = 0;

    led_pattern_sequencer #(
        .TICK_DIV(16),
        .CNT_W   (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_req (mode_req),
        .mode_sel (mode_sel),
        .mode_ack (mode_ack),
        .speed    (speed),
        .pause    (pause),
        .mode     (mode),
        .step_tick(step_tick),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until step_tick is seen; n = maxc+1 on timeout.
    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_tick && n <= maxc);
    endtask

    task automatic wait_ack(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mode_ack && n <= maxc);
    endtask

    logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                    8'h02};
    logic [7:0] exp_led;
    int n;
    int bad;

    initial begin
        rst_n    = 1'b0;
        mode_req = 1'b0;
        mode_sel = 2'd0;
        speed    = 2'd0;
        pause    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_led", led, 8'h00);
        chk("rst_mode", mode, 2'd0);
        chk("rst_ack", mode_ack, 1'b0);
        chk("rst_tick", step_tick, 1'b0);
        rst_n = 1'b1;
        wait_tick(40, n);
        chk("first_tick_latency", n, 16);

        // CHASE at speed 0
        mode_req = 1'b1;
        mode_sel = 2'd2;
        wait_ack(40, n);
        chk("chase_ack_latency", n, 16);
        chk("chase_ack_tick", step_tick, 1'b1);
        chk("chase_init_led", led, 8'h01);
        chk("chase_mode", mode, 2'd2);
        mode_req = 1'b0;
        @(negedge clk);
        chk("chase_ack_pulse", mode_ack, 1'b0);
        exp_led = 8'h01;
        for (int i = 0; i < 8; i++) begin
            wait_tick(40, n);
            exp_led = {exp_led[6:0], exp_led[7]};
            chk("chase_period", n, (i == 0) ? 15 : 16);
            chk("chase_led", led, exp_led);
        end
        for (int i = 0; i < 3; i++) wait_tick(40, n);
        chk("chase_led_08", led, 8'h08);

        // Asynchronous reset mid-CHASE, checked between clock edges
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 8'h00);
        chk("async_rst_mode", mode, 2'd0);
        chk("async_rst_ack", mode_ack, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(40, n);
        chk("tick_after_rst", n, 16);
        chk("off_led", led, 8'h00);

        // BOUNCE at speed 0
        mode_req = 1'b1;
        mode_sel = 2'd3;
        wait_ack(40, n);
        chk("bounce_ack_latency", n, 16);
        chk("bounce_init_led", led, 8'h01);
        chk("bounce_mode", mode, 2'd3);
        mode_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            wait_tick(40, n);
            chk("bounce_led", led, bounce_exp[i]);
        end

        // BINARY at speed 2
        speed    = 2'd2;
        mode_req = 1'b1;
        mode_sel = 2'd1;
        wait_ack(40, n);
        chk("binary_ack_latency", n, 4);
        chk("binary_init_led", led, 8'h00);
        chk("binary_mode", mode, 2'd1);
        mode_req = 1'b0;
        exp_led = 8'h00;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            wait_tick(20, n);
            exp_led = exp_led + 8'h01;
            if (n != ((i == 0) ? 4 : 4) || led !== exp_led) bad++;
        end
        chk("binary_steps_bad", bad, 0);
        chk("binary_wrap_led", led, 8'h00);

        // Pause in CHASE at led=10
        mode_req = 1'b1;
        mode_sel = 2'd2;
        wait_ack(20, n);
        chk("chase2_ack_latency", n, 4);
        chk("chase2_init_led", led, 8'h01);
        mode_req = 1'b0;
        for (int i = 0; i < 4; i++) wait_tick(20, n);
        chk("chase2_led_10", led, 8'h10);
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (step_tick !== 1'b0 || led !== 8'h10) bad++;
        end
        chk("pause_frozen_bad", bad, 0);
        mode_req = 1'b1;
        mode_sel = 2'd0;
        @(negedge clk);
        chk("pause_ack", mode_ack, 1'b1);
        chk("pause_off_led", led, 8'h00);
        chk("pause_off_mode", mode, 2'd0);
        // Request still high while ack is high: must not apply twice.
        @(negedge clk);
        chk("no_double_ack", mode_ack, 1'b0);
        mode_req = 1'b0;

        // Mid-count speed increase
        pause = 1'b0;
        repeat (10) @(negedge clk);
        speed = 2'd3;
        @(negedge clk);
        chk("speedup_tick_next", step_tick, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(10, n);
            chk("speed3_period", n, 2);
        end

        // Request dropped before a tick
        mode_req = 1'b1;
        mode_sel = 2'd2;
        @(negedge clk);
        mode_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mode_ack !== 1'b0) bad++;
        end
        chk("dropped_req_no_ack", bad, 0);
        chk("dropped_req_mode", mode, 2'd0);
        chk("dropped_req_led", led, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
